// File: rtl/bh_prog_loader.sv
// bh_prog_loader: streams brainfuck source bytes into program memory as 3-bit codes,
// checks bracket balance and size, appends a halt word and releases the core when valid.
module bh_prog_loader #(
  parameter int prgmem_addr_width = 8,
  parameter int depth_width       = 4,
  parameter int start_addr        = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         i_start,
  input  logic                         i_char_valid,
  input  logic [7:0]                   i_char,
  input  logic                         i_char_last,
  output logic                         o_char_ready,
  output logic                         o_prgmem_in,
  output logic [prgmem_addr_width-1:0] o_prgmem_addr,
  output logic [2:0]                   o_prgmem_data,
  output logic                         o_cpu_hold,
  output logic                         o_done,
  output logic                         o_error,
  output logic [prgmem_addr_width-1:0] o_length
);
  // state | meaning
  // IDLE  | after reset; core held, waiting for i_start
  // LOAD  | accepting source bytes, one per cycle
  // TERM  | writing the 000 halt word at wp
  // DONE  | program resident, core released
  // ERROR | load aborted; core held until i_start
  typedef enum logic [2:0] {IDLE, LOAD, TERM, DONE, ERROR} state_t;

  localparam logic [prgmem_addr_width-1:0] addr_start = prgmem_addr_width'(start_addr);
  localparam logic [prgmem_addr_width-1:0] addr_one   = prgmem_addr_width'(1);
  localparam logic [prgmem_addr_width-1:0] addr_last  = {prgmem_addr_width{1'b1}};
  localparam logic [depth_width-1:0]       depth_one  = depth_width'(1);
  localparam logic [depth_width-1:0]       depth_max  = {depth_width{1'b1}};

  state_t                         state_q, state_d;
  logic [prgmem_addr_width-1:0]   wp_q, wp_d;
  logic [depth_width-1:0]         depth_q, depth_d;
  logic [prgmem_addr_width-1:0]   length_q, length_d;
  logic                           ready_q, ready_d;
  logic                           wr_q, wr_d;
  logic [prgmem_addr_width-1:0]   addr_q, addr_d;
  logic [2:0]                     data_q, data_d;
  logic                           hold_q, hold_d;
  logic                           done_q, done_d;
  logic                           error_q, error_d;

  logic                           is_cmd, is_open, is_close;
  logic [2:0]                     code;
  logic [depth_width-1:0]         depth_upd;
  logic                           byte_err;
  logic                           accept;

  always_comb begin
    is_cmd = 1'b1;
    code   = 3'b000;
    case (i_char)
      8'h2B:   code = 3'b001;
      8'h2D:   code = 3'b010;
      8'h3E:   code = 3'b011;
      8'h3C:   code = 3'b100;
      8'h2E:   code = 3'b101;
      8'h5B:   code = 3'b110;
      8'h5D:   code = 3'b111;
      default: is_cmd = 1'b0;
    endcase
  end

  assign is_open  = (i_char == 8'h5B);
  assign is_close = (i_char == 8'h5D);
  assign accept   = ready_q && i_char_valid;

  always_comb begin
    depth_upd = depth_q;
    if (is_open)       depth_upd = depth_q + depth_one;
    else if (is_close) depth_upd = depth_q - depth_one;
  end

  // the last slot is kept free so the halt word always fits
  assign byte_err = (is_close && (depth_q == '0)) ||
                    (is_open && (depth_q == depth_max)) ||
                    (is_cmd && (wp_q == addr_last));

  always_comb begin
    state_d  = state_q;
    wp_d     = wp_q;
    depth_d  = depth_q;
    length_d = length_q;
    wr_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (i_start) begin
          state_d  = LOAD;
          wp_d     = addr_start;
          depth_d  = '0;
          length_d = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          if (byte_err) begin
            state_d = ERROR;
          end else begin
            // an unbalanced final byte is itself legal and still lands; only the halt word is withheld
            if (is_cmd) begin
              wr_d     = 1'b1;
              addr_d   = wp_q;
              data_d   = code;
              wp_d     = wp_q + addr_one;
              length_d = length_q + addr_one;
            end
            depth_d = depth_upd;
            if (i_char_last) state_d = (depth_upd == '0) ? TERM : ERROR;
          end
        end
      end
      TERM: begin
        wr_d    = 1'b1;
        addr_d  = wp_q;
        data_d  = 3'b000;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == LOAD);
    hold_d  = (state_d != DONE);
    done_d  = (state_d == DONE);
    error_d = (state_d == ERROR);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      wp_q     <= addr_start;
      depth_q  <= '0;
      length_q <= '0;
      ready_q  <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= addr_start;
      data_q   <= 3'b000;
      hold_q   <= 1'b1;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wp_q     <= wp_d;
      depth_q  <= depth_d;
      length_q <= length_d;
      ready_q  <= ready_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      hold_q   <= hold_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  assign o_char_ready  = ready_q;
  assign o_prgmem_in   = wr_q;
  assign o_prgmem_addr = addr_q;
  assign o_prgmem_data = data_q;
  assign o_cpu_hold    = hold_q;
  assign o_done        = done_q;
  assign o_error       = error_q;
  assign o_length      = length_q;
endmodule
